sr_task_queue_ctrl: RTL and testbench

Command-side controller for the 16-cell shift-register task queue. Accepts ENQ/DEQ/REM/BLK commands from the scheduler over a valid/ready handshake. Snapshots the queue's per-cell state and computes the per-cell control vectors (`enqueue`, `dequeue`, `remove`, `que_act`, `que_blk`), driving them for exactly one clock. Returns a response (dequeued TID, error flag) after the queue has settled. Sits between the scheduler FSM and the queue array.

---
 rtl/sr_task_queue_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_sr_task_queue_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_task_queue_ctrl.sv
// ---------------------------------------------------------------------------
// sr_task_queue_ctrl
//
// Command-side controller for the shift-register task queue. The scheduler
// hands over ENQ/DEQ/REM/BLK commands on a valid/ready handshake. The
// controller snapshots the per-cell queue state and turns each command into
// per-cell control vectors. Those vectors are driven for exactly one clock.
// After a one-cycle settle wait, it returns a response pulse.
//
// Command / response latency is fixed at 3 cycles regardless of error, and a
// new command can be accepted every 4 cycles.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op            00 ENQ, 01 DEQ, 10 REM, 11 BLK
//   cmd_tid           task id for ENQ/REM/BLK
//   cmd_info          task info for ENQ (priority in the low PRIO_W bits)
//   cmd_blk           for BLK: 1 = block, 0 = activate
//   q_empty           per-cell empty flags, occupancy contiguous from cell 0
//   q_tid, q_info     per-cell task id / info, flattened, cell i at [i*W +: W]
//   new_task_id/info  registered task to insert on ENQ
//   enqueue, dequeue, remove, que_act, que_blk
//                     per-cell control vectors, valid during ISSUE only
//   rsp_valid         one-cycle response pulse
//   rsp_tid           affected task id (cmd_tid for ENQ and for errors)
//   rsp_err           command was rejected
//
// Build option
//   SR_TASK_QUEUE_CTRL_DUP_CHECK_EN : when defined, an ENQ whose TID is
//   already present in the queue is rejected instead of being inserted.
// ---------------------------------------------------------------------------
module sr_task_queue_ctrl #(
   parameter int DEPTH  = 16,
   parameter int TID_W  = 4,
   parameter int INFO_W = 32,
   parameter int PRIO_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [TID_W-1:0]        cmd_tid,
   input  logic [INFO_W-1:0]       cmd_info,
   input  logic                    cmd_blk,
   input  logic [DEPTH-1:0]        q_empty,
   input  logic [DEPTH*TID_W-1:0]  q_tid,
   input  logic [DEPTH*INFO_W-1:0] q_info,
   output logic [TID_W-1:0]        new_task_id,
   output logic [INFO_W-1:0]       new_task_info,
   output logic [DEPTH-1:0]        enqueue,
   output logic [DEPTH-1:0]        dequeue,
   output logic [DEPTH-1:0]        remove,
   output logic [DEPTH-1:0]        que_act,
   output logic [DEPTH-1:0]        que_blk,
   output logic                    rsp_valid,
   output logic [TID_W-1:0]        rsp_tid,
   output logic                    rsp_err
);

   localparam logic [1:0] OP_ENQ = 2'b00;
   localparam logic [1:0] OP_DEQ = 2'b01;
   localparam logic [1:0] OP_REM = 2'b10;
   localparam logic [1:0] OP_BLK = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_RESP
   } state_t;

   state_t state;

   logic             full;
   logic             empty;
   logic             dup_err;
   logic             hit_ins;
   logic             match_any;
   logic [TID_W-1:0] match_tid;
   logic [DEPTH-1:0] ins_therm;
   logic [DEPTH-1:0] rem_therm;
   logic [DEPTH-1:0] match_onehot;

   logic [DEPTH-1:0] nxt_enqueue;
   logic [DEPTH-1:0] nxt_dequeue;
   logic [DEPTH-1:0] nxt_remove;
   logic [DEPTH-1:0] nxt_que_act;
   logic [DEPTH-1:0] nxt_que_blk;
   logic [TID_W-1:0] nxt_rsp_tid;
   logic             nxt_rsp_err;

   logic [TID_W-1:0] pend_tid;
   logic             pend_err;

   // Only the priority slice of each cell's info is inspected here; the rest
   // of the info bus passes straight through to the queue cells.
   logic             unused_info;
   assign unused_info = ^q_info;

   assign cmd_ready = (state == S_IDLE);
   assign full      = ~q_empty[DEPTH-1];
   assign empty     = q_empty[0];

   // Scan the queue from the head. The insertion point is the first cell that
   // is empty or holds a strictly lower priority, so equal priorities keep
   // FIFO order. Because of the OR-accumulation, every cell from the
   // insertion point onward is set, which gives the thermometer shape
   // directly. The match scan works the same way for the lowest cell holding
   // cmd_tid. The one-hot form of the match is the rising edge of its
   // thermometer.
   always_comb begin
      hit_ins   = 1'b0;
      match_any = 1'b0;
      match_tid = '0;
      ins_therm = '0;
      rem_therm = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_ins = hit_ins | q_empty[i]
                 | (q_info[i*INFO_W +: PRIO_W] < cmd_info[PRIO_W-1:0]);
         ins_therm[i] = hit_ins;
         if (!match_any && !q_empty[i] && (q_tid[i*TID_W +: TID_W] == cmd_tid)) begin
            match_any = 1'b1;
            match_tid = q_tid[i*TID_W +: TID_W];
         end
         rem_therm[i] = match_any;
      end
      match_onehot = rem_therm & ~(rem_therm << 1);
   end

`ifdef SR_TASK_QUEUE_CTRL_DUP_CHECK_EN
   assign dup_err = match_any;
`else
   assign dup_err = 1'b0;
`endif

   // Decode the command into the vectors and response it would produce if
   // accepted this cycle. A rejected command leaves every vector at zero.
   // It reports cmd_tid, so the scheduler can tell which request failed.
   always_comb begin
      nxt_enqueue = '0;
      nxt_dequeue = '0;
      nxt_remove  = '0;
      nxt_que_act = '0;
      nxt_que_blk = '0;
      nxt_rsp_tid = cmd_tid;
      nxt_rsp_err = 1'b0;
      case (cmd_op)
         OP_ENQ: begin
            nxt_rsp_err = full | dup_err;
            if (!nxt_rsp_err) nxt_enqueue = ins_therm;
         end
         OP_DEQ: begin
            nxt_rsp_err = empty;
            if (!nxt_rsp_err) begin
               nxt_dequeue = '1;
               nxt_rsp_tid = q_tid[TID_W-1:0];
            end
         end
         OP_REM: begin
            nxt_rsp_err = ~match_any;
            if (!nxt_rsp_err) begin
               nxt_remove  = rem_therm;
               nxt_rsp_tid = match_tid;
            end
         end
         default: begin
            nxt_rsp_err = ~match_any;
            if (!nxt_rsp_err) begin
               if (cmd_blk) nxt_que_blk = match_onehot;
               else         nxt_que_act = match_onehot;
               nxt_rsp_tid = match_tid;
            end
         end
      endcase
   end

   // The FSM walks IDLE -> ISSUE -> SETTLE -> RESP on every command, so
   // latency does not depend on the outcome. On accept it registers the
   // vectors and parks the response. The vectors are cleared on the way out
   // of ISSUE, which keeps them alive for exactly one cycle. The parked
   // response is released in RESP. Reset drops any parked response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         enqueue       <= '0;
         dequeue       <= '0;
         remove        <= '0;
         que_act       <= '0;
         que_blk       <= '0;
         new_task_id   <= '0;
         new_task_info <= '0;
         pend_tid      <= '0;
         pend_err      <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_tid       <= '0;
         rsp_err       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  state         <= S_ISSUE;
                  enqueue       <= nxt_enqueue;
                  dequeue       <= nxt_dequeue;
                  remove        <= nxt_remove;
                  que_act       <= nxt_que_act;
                  que_blk       <= nxt_que_blk;
                  new_task_id   <= cmd_tid;
                  new_task_info <= cmd_info;
                  pend_tid      <= nxt_rsp_tid;
                  pend_err      <= nxt_rsp_err;
               end
            end
            S_ISSUE: begin
               state   <= S_SETTLE;
               enqueue <= '0;
               dequeue <= '0;
               remove  <= '0;
               que_act <= '0;
               que_blk <= '0;
            end
            S_SETTLE: begin
               state     <= S_RESP;
               rsp_valid <= 1'b1;
               rsp_tid   <= pend_tid;
               rsp_err   <= pend_err;
            end
            default: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_task_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sr_task_queue_ctrl
//
// Directed bench for sr_task_queue_ctrl. Each command is issued through
// applyStimulus. Hand-computed expectations are checked in ISSUE, SETTLE,
// RESP and the following idle cycle. Queue contents are composed with
// clearQueue/setCell before each command.
// ---------------------------------------------------------------------------
module tb_sr_task_queue_ctrl;

   localparam int DEPTH  = 16;
   localparam int TID_W  = 4;
   localparam int INFO_W = 32;

   logic                    clk;
   logic                    rst;
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [1:0]              cmd_op;
   logic [TID_W-1:0]        cmd_tid;
   logic [INFO_W-1:0]       cmd_info;
   logic                    cmd_blk;
   logic [DEPTH-1:0]        q_empty;
   logic [DEPTH*TID_W-1:0]  q_tid;
   logic [DEPTH*INFO_W-1:0] q_info;
   logic [TID_W-1:0]        new_task_id;
   logic [INFO_W-1:0]       new_task_info;
   logic [DEPTH-1:0]        enqueue;
   logic [DEPTH-1:0]        dequeue;
   logic [DEPTH-1:0]        remove;
   logic [DEPTH-1:0]        que_act;
   logic [DEPTH-1:0]        que_blk;
   logic                    rsp_valid;
   logic [TID_W-1:0]        rsp_tid;
   logic                    rsp_err;

   int checks_total;
   int checks_passed;

   sr_task_queue_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_tid       (cmd_tid),
      .cmd_info      (cmd_info),
      .cmd_blk       (cmd_blk),
      .q_empty       (q_empty),
      .q_tid         (q_tid),
      .q_info        (q_info),
      .new_task_id   (new_task_id),
      .new_task_info (new_task_info),
      .enqueue       (enqueue),
      .dequeue       (dequeue),
      .remove        (remove),
      .que_act       (que_act),
      .que_blk       (que_blk),
      .rsp_valid     (rsp_valid),
      .rsp_tid       (rsp_tid),
      .rsp_err       (rsp_err)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks_total++;
      if (observed === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic clearQueue();
      q_empty = '1;
      q_tid   = '0;
      q_info  = '0;
   endtask

   task automatic setCell(input int idx, input logic [3:0] tid, input logic [7:0] prio);
      q_empty[idx]              = 1'b0;
      q_tid[idx*TID_W +: TID_W] = tid;
      q_info[idx*INFO_W +: INFO_W] = {24'h0, prio};
   endtask

   // Issue one command from an idle cycle and check the whole 4-cycle walk.
   // The cmd_* inputs are scrambled after accept so that a response depending
   // on live inputs instead of the captured command gets caught.
   task automatic applyStimulus(input string tag, input logic [1:0] op,
                                input logic [3:0] tid, input logic [31:0] info,
                                input logic blk,
                                input logic [15:0] exp_enq, input logic [15:0] exp_deq,
                                input logic [15:0] exp_rem, input logic [15:0] exp_act,
                                input logic [15:0] exp_blk,
                                input logic [3:0] exp_tid, input logic exp_err);
      checkOutput({tag, ".ready_idle"}, 32'(cmd_ready), 32'd1);
      cmd_op    = op;
      cmd_tid   = tid;
      cmd_info  = info;
      cmd_blk   = blk;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = ~op;
      cmd_tid   = ~tid;
      cmd_info  = ~info;
      cmd_blk   = ~blk;
      // ISSUE
      checkOutput({tag, ".ready_issue"}, 32'(cmd_ready), 32'd0);
      checkOutput({tag, ".enqueue"}, 32'(enqueue), 32'(exp_enq));
      checkOutput({tag, ".dequeue"}, 32'(dequeue), 32'(exp_deq));
      checkOutput({tag, ".remove"},  32'(remove),  32'(exp_rem));
      checkOutput({tag, ".que_act"}, 32'(que_act), 32'(exp_act));
      checkOutput({tag, ".que_blk"}, 32'(que_blk), 32'(exp_blk));
      if (op == 2'b00) begin
         checkOutput({tag, ".new_tid"},  32'(new_task_id), 32'(tid));
         checkOutput({tag, ".new_info"}, new_task_info, info);
      end
      @(posedge clk);
      #1;
      // SETTLE
      checkOutput({tag, ".vec_settle"},
                  32'(enqueue | dequeue | remove | que_act | que_blk), 32'd0);
      checkOutput({tag, ".rsp_early"}, 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      // RESP
      checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, ".rsp_tid"},   32'(rsp_tid),   32'(exp_tid));
      checkOutput({tag, ".rsp_err"},   32'(rsp_err),   32'(exp_err));
      @(posedge clk);
      #1;
      // back in IDLE
      checkOutput({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".ready_back"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_tid   = '0;
      cmd_info  = '0;
      cmd_blk   = 1'b0;
      clearQueue();

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.vectors",
                  32'(enqueue | dequeue | remove | que_act | que_blk), 32'd0);
      checkOutput("rst.rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst.rsp_err",   32'(rsp_err),   32'd0);
      checkOutput("rst.rsp_tid",   32'(rsp_tid),   32'd0);
      checkOutput("rst.new_tid",   32'(new_task_id), 32'd0);
      checkOutput("rst.new_info",  new_task_info,    32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst.ready", 32'(cmd_ready), 32'd1);

      // ENQ into empty queue: insert at head
      clearQueue();
      applyStimulus("enq_empty", 2'b00, 4'd3, 32'h0000_0005, 1'b0,
                    16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 4'd3, 1'b0);

      // ENQ prio 5 behind 9,5,2: goes after the existing 5 (FIFO on ties)
      clearQueue();
      setCell(0, 4'd1, 8'd9);
      setCell(1, 4'd2, 8'd5);
      setCell(2, 4'd4, 8'd2);
      applyStimulus("enq_prio", 2'b00, 4'd6, 32'hABCD_0005, 1'b0,
                    16'hFFFC, 16'h0, 16'h0, 16'h0, 16'h0, 4'd6, 1'b0);

      // ENQ prio 10 ahead of everything
      applyStimulus("enq_head", 2'b00, 4'd8, 32'h0000_000A, 1'b0,
                    16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0, 4'd8, 1'b0);

      // Duplicate TID 2 (cell 1), prio 1 -> would land at cell 3
      `ifdef SR_TASK_QUEUE_CTRL_DUP_CHECK_EN
      applyStimulus("enq_dup", 2'b00, 4'd2, 32'h0000_0001, 1'b0,
                    16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'd2, 1'b1);
      `else
      applyStimulus("enq_dup", 2'b00, 4'd2, 32'h0000_0001, 1'b0,
                    16'hFFF8, 16'h0, 16'h0, 16'h0, 16'h0, 4'd2, 1'b0);
      `endif

      // DEQ on empty queue: rejected, response carries cmd_tid
      clearQueue();
      applyStimulus("deq_empty", 2'b01, 4'hA, 32'h0, 1'b0,
                    16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'hA, 1'b1);

      // DEQ with head tid 7
      setCell(0, 4'd7, 8'd3);
      applyStimulus("deq", 2'b01, 4'd0, 32'h0, 1'b0,
                    16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 4'd7, 1'b0);

      // Queue of tids 1,2,5,3,9,11 for REM/BLK
      clearQueue();
      setCell(0, 4'd1,  8'd9);
      setCell(1, 4'd2,  8'd8);
      setCell(2, 4'd5,  8'd7);
      setCell(3, 4'd3,  8'd6);
      setCell(4, 4'd9,  8'd5);
      setCell(5, 4'd11, 8'd4);
      applyStimulus("rem9", 2'b10, 4'd9, 32'h0, 1'b0,
                    16'h0, 16'h0, 16'hFFF0, 16'h0, 16'h0, 4'd9, 1'b0);
      applyStimulus("blk9", 2'b11, 4'd9, 32'h0, 1'b1,
                    16'h0, 16'h0, 16'h0, 16'h0, 16'h0010, 4'd9, 1'b0);
      applyStimulus("act2", 2'b11, 4'd2, 32'h0, 1'b0,
                    16'h0, 16'h0, 16'h0, 16'h0002, 16'h0, 4'd2, 1'b0);
      applyStimulus("blk12", 2'b11, 4'd12, 32'h0, 1'b1,
                    16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'd12, 1'b1);
      applyStimulus("rem12", 2'b10, 4'd12, 32'h0, 1'b0,
                    16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'd12, 1'b1);

      // Same TID in cells 2 and 4: the lowest cell wins
      setCell(4, 4'd5, 8'd5);
      applyStimulus("rem_dup", 2'b10, 4'd5, 32'h0, 1'b0,
                    16'h0, 16'h0, 16'hFFFC, 16'h0, 16'h0, 4'd5, 1'b0);

      // TID at the last cell of a full queue
      clearQueue();
      for (int i = 0; i < DEPTH; i++) setCell(i, 4'(i), 8'd1);
      applyStimulus("blk_last", 2'b11, 4'd15, 32'h0, 1'b1,
                    16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 4'd15, 1'b0);

      // Full queue: high-priority ENQ still rejected
      applyStimulus("enq_full", 2'b00, 4'd0, 32'h0000_00FF, 1'b0,
                    16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 1'b1);

      // Reset during ISSUE drops the command
      clearQueue();
      cmd_op    = 2'b00;
      cmd_tid   = 4'd5;
      cmd_info  = 32'h0000_0004;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checkOutput("rst_issue.enqueue", 32'(enqueue), 32'h0000_FFFF);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rst_issue.vectors",
                  32'(enqueue | dequeue | remove | que_act | que_blk), 32'd0);
      checkOutput("rst_issue.rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_issue.rsp_tid",   32'(rsp_tid),   32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_issue.ready",      32'(cmd_ready), 32'd1);
      checkOutput("rst_issue.rsp_valid2", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("rst_issue.rsp_valid3", 32'(rsp_valid), 32'd0);

      // Controller is usable again after the aborted command
      setCell(0, 4'd7, 8'd2);
      applyStimulus("deq_after_rst", 2'b01, 4'd0, 32'h0, 1'b0,
                    16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 4'd7, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
